// File: rtl/sd_cmd_controller.sv
// SD CMD line sequencer: sends a 48-bit command frame, then collects and checks
// the card response (timeout, CRC7, end bit, index).
module sd_cmd_controller #(
    parameter int TIMEOUT_TICKS = 64,
    parameter int GAP_TICKS     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sd_tick,
    input  logic         cmd_start,
    input  logic [15:0]  command_reg,
    input  logic [31:0]  argument_reg,
    input  logic         cmd_pin_in,
    output logic         cmd_pin_out,
    output logic         cmd_pin_oe,
    output logic         cmd_inhibit,
    output logic         cmd_complete,
    output logic [3:0]   error_status,
    input  logic [3:0]   error_clear,
    output logic [127:0] response_out
);
    localparam int CW = 16;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, CHECK, GAP} state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    state_t         state_q, state_d;
    logic [47:0]    frame_q, frame_d;
    logic [5:0]     idx_q, idx_d;
    logic [1:0]     type_q, type_d;
    logic           crc_en_q, crc_en_d, idx_en_q, idx_en_d;
    logic [7:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [135:0]   rx_q, rx_d;
    logic [6:0]     crc_q, crc_d;
    logic           out_q, out_d, oe_q, oe_d, inhibit_q, inhibit_d, complete_q, complete_d;
    logic [3:0]     err_q, err_d, new_err;
    logic [127:0]   resp_q, resp_d;

    logic [39:0] hdr;
    logic        long_resp;
    logic [7:0]  rx_len, rx_pos;
    logic        unused_ok;

    assign hdr       = {2'b01, command_reg[13:8], argument_reg};
    assign long_resp = (type_q == 2'b01);
    assign rx_len    = long_resp ? 8'd136 : 8'd48;
    // Frame-bit index of the bit arriving on this tick (MSB of frame = rx_len-1).
    assign rx_pos    = rx_len - 8'd1 - bit_cnt_q;
    assign unused_ok = ^{command_reg[15:14], command_reg[7:5], command_reg[2], rx_q[135:128]};

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        type_d     = type_q;
        crc_en_d   = crc_en_q;
        idx_en_d   = idx_en_q;
        bit_cnt_d  = bit_cnt_q;
        tick_cnt_d = tick_cnt_q;
        rx_d       = rx_q;
        crc_d      = crc_q;
        out_d      = out_q;
        oe_d       = oe_q;
        inhibit_d  = inhibit_q;
        complete_d = 1'b0;
        resp_d     = resp_q;
        new_err    = 4'b0000;
        case (state_q)
            IDLE: if (cmd_start && !inhibit_q) begin
                idx_d     = command_reg[13:8];
                type_d    = command_reg[1:0];
                crc_en_d  = command_reg[3];
                idx_en_d  = command_reg[4];
                frame_d   = {hdr, crc7_40(hdr), 1'b1};
                bit_cnt_d = 8'd0;
                inhibit_d = 1'b1;
                state_d   = SEND;
            end
            SEND: if (sd_tick) begin
                if (bit_cnt_q != 8'd48) begin
                    out_d     = frame_q[47];
                    oe_d      = 1'b1;
                    frame_d   = {frame_q[46:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 8'd1;
                end else begin
                    out_d      = 1'b1;
                    oe_d       = 1'b0;
                    tick_cnt_d = '0;
                    state_d    = (type_q == 2'b00) ? GAP : WAIT;
                end
            end
            WAIT: if (sd_tick) begin
                if (!cmd_pin_in) begin
                    // Start bit already known to be 0; CRC of a 0 from init 0 stays 0.
                    rx_d      = '0;
                    bit_cnt_d = 8'd1;
                    crc_d     = 7'h00;
                    state_d   = RECV;
                end else if (tick_cnt_q == TO_LAST) begin
                    new_err[0] = 1'b1;
                    tick_cnt_d = '0;
                    state_d    = GAP;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            RECV: if (sd_tick) begin
                rx_d      = {rx_q[134:0], cmd_pin_in};
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (rx_pos >= 8'd8 && (!long_resp || rx_pos <= 8'd127))
                    crc_d = crc7_step(crc_q, cmd_pin_in);
                if (bit_cnt_d == rx_len) state_d = CHECK;
            end
            CHECK: begin
                new_err[2] = !rx_q[0];
                new_err[1] = crc_en_q && (rx_q[7:1] != crc_q);
                new_err[3] = idx_en_q && !long_resp && (rx_q[45:40] != idx_q);
                resp_d     = long_resp ? {8'h00, rx_q[127:8]} : {96'h0, rx_q[39:8]};
                complete_d = (new_err == 4'b0000);
                tick_cnt_d = '0;
                state_d    = GAP;
            end
            GAP: if (sd_tick) begin
                if (tick_cnt_q == GAP_LAST) begin
                    inhibit_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // New errors take priority over a same-cycle clear.
        err_d = (err_q & ~error_clear) | new_err;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            idx_q      <= '0;
            type_q     <= '0;
            crc_en_q   <= 1'b0;
            idx_en_q   <= 1'b0;
            bit_cnt_q  <= '0;
            tick_cnt_q <= '0;
            rx_q       <= '0;
            crc_q      <= '0;
            out_q      <= 1'b1;
            oe_q       <= 1'b0;
            inhibit_q  <= 1'b0;
            complete_q <= 1'b0;
            err_q      <= '0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            type_q     <= type_d;
            crc_en_q   <= crc_en_d;
            idx_en_q   <= idx_en_d;
            bit_cnt_q  <= bit_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            rx_q       <= rx_d;
            crc_q      <= crc_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            inhibit_q  <= inhibit_d;
            complete_q <= complete_d;
            err_q      <= err_d;
            resp_q     <= resp_d;
        end
    end

    assign cmd_pin_out  = out_q;
    assign cmd_pin_oe   = oe_q;
    assign cmd_inhibit  = inhibit_q;
    assign cmd_complete = complete_q;
    assign error_status = err_q;
    assign response_out = resp_q;
endmodule

// File: tb/tb_sd_cmd_controller.sv
// Directed bench for sd_cmd_controller: wire frames, responses, CRC error,
// timeout, ignored restart and mid-frame reset.
module tb_sd_cmd_controller;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         sd_tick = 1'b0;
    logic         cmd_start = 1'b0;
    logic [15:0]  command_reg = '0;
    logic [31:0]  argument_reg = '0;
    logic         cmd_pin_in = 1'b1;
    logic         cmd_pin_out, cmd_pin_oe, cmd_inhibit, cmd_complete;
    logic [3:0]   error_status;
    logic [3:0]   error_clear = '0;
    logic [127:0] response_out;

    int errors = 0;
    int checks = 0;
    int complete_cnt = 0;
    logic [47:0] wire_bits;
    int oe_cnt;

    sd_cmd_controller #(.TIMEOUT_TICKS(64), .GAP_TICKS(8)) dut (
        .clock(clock), .reset(reset), .sd_tick(sd_tick), .cmd_start(cmd_start),
        .command_reg(command_reg), .argument_reg(argument_reg), .cmd_pin_in(cmd_pin_in),
        .cmd_pin_out(cmd_pin_out), .cmd_pin_oe(cmd_pin_oe), .cmd_inhibit(cmd_inhibit),
        .cmd_complete(cmd_complete), .error_status(error_status), .error_clear(error_clear),
        .response_out(response_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (cmd_complete) complete_cnt <= complete_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock) sd_tick = 1'b1;
        @(negedge clock) sd_tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic start(input logic [15:0] cmd, input logic [31:0] arg);
        @(negedge clock);
        command_reg  = cmd;
        argument_reg = arg;
        cmd_start    = 1'b1;
        @(negedge clock) cmd_start = 1'b0;
    endtask

    // 49 ticks: 48 frame bits plus the release tick; optional restart pulse mid-frame.
    task automatic send(input int pulse_at, output logic [47:0] w, output int n_oe);
        w = '0;
        n_oe = 0;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (cmd_pin_oe) begin
                w = {w[46:0], cmd_pin_out};
                n_oe++;
            end
            if (i == pulse_at) begin
                command_reg  = 16'h3F00;
                argument_reg = 32'hFFFF_FFFF;
                cmd_start    = 1'b1;
                @(negedge clock) cmd_start = 1'b0;
            end
        end
    endtask

    task automatic respond(input int idle, input logic [47:0] r);
        for (int i = 0; i < idle; i++) tick();
        for (int i = 47; i >= 0; i--) begin
            cmd_pin_in = r[i];
            tick();
        end
        cmd_pin_in = 1'b1;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic gap_check(input string tag);
        for (int i = 0; i < 7; i++) tick();
        check({tag, "_inhibit_gap7"}, {127'b0, cmd_inhibit}, 128'd1);
        tick();
        check({tag, "_inhibit_gap8"}, {127'b0, cmd_inhibit}, 128'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_out", {127'b0, cmd_pin_out}, 128'd1);
        check("rst_oe", {127'b0, cmd_pin_oe}, 128'd0);
        check("rst_inhibit", {127'b0, cmd_inhibit}, 128'd0);
        check("rst_err", {124'b0, error_status}, 128'd0);
        check("rst_resp", response_out, 128'd0);
        @(negedge clock) reset = 1'b0;

        // CMD0, no response
        start(16'h0000, 32'h0);
        check("cmd0_inhibit_set", {127'b0, cmd_inhibit}, 128'd1);
        send(-1, wire_bits, oe_cnt);
        check("cmd0_wire", {80'b0, wire_bits}, {80'b0, 48'h400000000095});
        check("cmd0_oe_ticks", 128'(oe_cnt), 128'd48);
        check("cmd0_release", {126'b0, cmd_pin_oe, cmd_pin_out}, 128'b01);
        gap_check("cmd0");
        check("cmd0_no_complete", 128'(complete_cnt), 128'd0);
        check("cmd0_err", {124'b0, error_status}, 128'd0);

        // CMD8 R7 with restart pulse mid-frame (must be ignored)
        start(16'h081A, 32'h0000_01AA);
        send(10, wire_bits, oe_cnt);
        check("cmd8_wire", {80'b0, wire_bits}, {80'b0, 48'h48000001AA87});
        check("cmd8_oe_ticks", 128'(oe_cnt), 128'd48);
        respond(4, 48'h08000001AA13);
        check("cmd8_complete", 128'(complete_cnt), 128'd1);
        check("cmd8_resp", response_out, 128'h1AA);
        check("cmd8_err", {124'b0, error_status}, 128'd0);
        gap_check("cmd8");

        // Reset clears response so the bad-CRC update is visible
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        check("rst2_resp", response_out, 128'd0);
        start(16'h081A, 32'h0000_01AA);
        send(-1, wire_bits, oe_cnt);
        respond(4, 48'h08000001AA15);
        check("badcrc_err", {124'b0, error_status}, 128'b0010);
        check("badcrc_no_complete", 128'(complete_cnt), 128'd1);
        check("badcrc_resp", response_out, 128'h1AA);
        gap_check("badcrc");
        @(negedge clock) error_clear = 4'b0010;
        @(negedge clock) error_clear = 4'b0000;
        check("badcrc_cleared", {124'b0, error_status}, 128'd0);

        // CMD17 with no card response: timeout
        start(16'h1102, 32'h0);
        send(-1, wire_bits, oe_cnt);
        check("cmd17_oe_ticks", 128'(oe_cnt), 128'd48);
        for (int i = 0; i < 63; i++) tick();
        check("cmd17_err_tick63", {124'b0, error_status}, 128'd0);
        tick();
        check("cmd17_err_tick64", {124'b0, error_status}, 128'b0001);
        gap_check("cmd17");
        check("cmd17_no_complete", 128'(complete_cnt), 128'd1);
        @(negedge clock) error_clear = 4'b1111;
        @(negedge clock) error_clear = 4'b0000;
        check("cmd17_cleared", {124'b0, error_status}, 128'd0);

        // Reset in the middle of a frame
        start(16'h0000, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        check("mid_oe_before", {127'b0, cmd_pin_oe}, 128'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_oe", {127'b0, cmd_pin_oe}, 128'd0);
        check("mid_rst_out", {127'b0, cmd_pin_out}, 128'd1);
        check("mid_rst_inhibit", {127'b0, cmd_inhibit}, 128'd0);
        check("mid_rst_err", {124'b0, error_status}, 128'd0);
        @(negedge clock) reset = 1'b0;
        start(16'h0000, 32'h0);
        send(-1, wire_bits, oe_cnt);
        check("after_rst_wire", {80'b0, wire_bits}, {80'b0, 48'h400000000095});
        check("after_rst_oe_ticks", 128'(oe_cnt), 128'd48);
        gap_check("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
